// File: rtl/box_draw_engine_if.sv
// box_draw_engine_if: command/pixel bundle between the control logic (master)
// and the box plotter (slave).
interface box_draw_engine_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [1:0]          mode;
  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                ready;
  logic                done;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;

  modport master (
    output start, mode, x_in, y_in, colour_in,
    input  ready, done, x_out, y_out, colour_out, plot
  );

  modport slave (
    input  start, mode, x_in, y_in, colour_in,
    output ready, done, x_out, y_out, colour_out, plot
  );
endinterface

// File: rtl/box_draw_engine.sv
// box_draw_engine: plots a BOX_W x BOX_H rectangle one pixel per clock,
// column-major, with draw/erase/flash/redraw commands.
// Optional screen-edge clipping is enabled by defining BOX_DRAW_CLIP_EN.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// DRAW  | one pixel per cycle, plot strobed
// DONE  | one-cycle done pulse
module box_draw_engine #(
  parameter int                    X_W          = 8,
  parameter int                    Y_W          = 8,
  parameter int                    COLOUR_W     = 3,
  parameter int                    BOX_W        = 8,
  parameter int                    BOX_H        = 8,
  parameter int                    SCREEN_W     = 160,
  parameter int                    SCREEN_H     = 120,
  parameter logic [COLOUR_W-1:0]   BG_COLOUR    = '0,
  parameter logic [COLOUR_W-1:0]   FLASH_COLOUR = '1
) (
  input logic              clock,
  input logic              reset,
  box_draw_engine_if.slave bus
);

  localparam int COL_W = $clog2(BOX_W + 1);
  localparam int ROW_W = $clog2(BOX_H + 1);

  localparam logic [1:0] MODE_DRAW   = 2'b00;
  localparam logic [1:0] MODE_ERASE  = 2'b01;
  localparam logic [1:0] MODE_FLASH  = 2'b10;
  localparam logic [1:0] MODE_REDRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic                drawing;
  logic                ready_i;
  logic                done_i;
  logic                col_last;
  logic                row_last;
  logic                last_pix;
  logic                in_view;

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;

  logic [X_W-1:0]      act_x, prev_x;
  logic [Y_W-1:0]      act_y, prev_y;
  logic [COLOUR_W-1:0] act_c, prev_c;
  logic [X_W-1:0]      x_pix;
  logic [Y_W-1:0]      y_pix;

  assign col_last = (col == COL_W'(BOX_W - 1));
  assign row_last = (row == ROW_W'(BOX_H - 1));
  assign last_pix = col_last && row_last;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drawing   = 1'b0;
    ready_i   = 1'b0;
    done_i    = 1'b0;
    case (state)
      IDLE: begin
        ready_i = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        drawing = 1'b1;
        if (last_pix) state_nxt = DONE;
      end
      DONE: begin
        done_i    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Column-major scan: row is the inner loop, both wrap after the last pixel.
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      col <= '0;
      row <= '0;
    end else if (drawing) begin
      if (row_last) begin
        row <= '0;
        col <= col_last ? '0 : col + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end
  end

  // Command latch: only a draw updates the saved previous box.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_x  <= '0;
      act_y  <= '0;
      act_c  <= '0;
      prev_x <= '0;
      prev_y <= '0;
      prev_c <= '0;
    end else if (accept) begin
      case (bus.mode)
        MODE_DRAW: begin
          act_x  <= bus.x_in;
          act_y  <= bus.y_in;
          act_c  <= bus.colour_in;
          prev_x <= bus.x_in;
          prev_y <= bus.y_in;
          prev_c <= bus.colour_in;
        end
        MODE_ERASE: begin
          act_x <= prev_x;
          act_y <= prev_y;
          act_c <= BG_COLOUR;
        end
        MODE_FLASH: begin
          act_x <= prev_x;
          act_y <= prev_y;
          act_c <= FLASH_COLOUR;
        end
        MODE_REDRAW: begin
          act_x <= prev_x;
          act_y <= prev_y;
          act_c <= prev_c;
        end
        default: begin
          act_x <= prev_x;
          act_y <= prev_y;
          act_c <= prev_c;
        end
      endcase
    end
  end

`ifdef BOX_DRAW_CLIP_EN
  // The carry bit matters here: a sum past 2^X_W must still count as off-screen.
  logic [X_W:0] x_full;
  logic [Y_W:0] y_full;

  assign x_full  = {1'b0, act_x} + (X_W+1)'(col);
  assign y_full  = {1'b0, act_y} + (Y_W+1)'(row);
  assign in_view = (x_full < (X_W+1)'(SCREEN_W)) && (y_full < (Y_W+1)'(SCREEN_H));
  assign x_pix   = x_full[X_W-1:0];
  assign y_pix   = y_full[Y_W-1:0];
`else
  assign in_view = 1'b1;
  assign x_pix   = act_x + X_W'(col);
  assign y_pix   = act_y + Y_W'(row);
`endif

  assign bus.ready      = ready_i;
  assign bus.done       = done_i;
  assign bus.plot       = drawing && in_view;
  assign bus.x_out      = drawing ? x_pix : '0;
  assign bus.y_out      = drawing ? y_pix : '0;
  assign bus.colour_out = drawing ? act_c : '0;

endmodule
